// File: rtl/traffic_phase_scheduler.sv
// Timed phase scheduler for a two-street intersection with a pedestrian WALK phase.
// Green dwell is bounded by MIN/MAX_GREEN; yellow, all-red and walk are fixed-length phases.
module traffic_phase_scheduler #(
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 10,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned WALK_TIME   = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_req,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    localparam logic [2:0] S_AG = 3'd0;
    localparam logic [2:0] S_AY = 3'd1;
    localparam logic [2:0] S_AR = 3'd2;
    localparam logic [2:0] S_BG = 3'd3;
    localparam logic [2:0] S_BY = 3'd4;
    localparam logic [2:0] S_BR = 3'd5;
    localparam logic [2:0] S_PW = 3'd6;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_wait_q, ped_wait_d;
    logic             next_b_q, next_b_d;
    logic             exit_a, exit_b;

    // A green yields once minimum dwell is met and the other side (or a pedestrian)
    // is waiting, unless its own traffic keeps it up to the maximum dwell.
    assign exit_a = (timer_q >= MIN_M1) && (TB || ped_wait_q) && (!TA || (timer_q >= MAX_M1));
    assign exit_b = (timer_q >= MIN_M1) && (TA || ped_wait_q) && (!TB || (timer_q >= MAX_M1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_AG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_AG: if (exit_a) state_d = S_AY;
            S_AY: if (timer_q == YEL_M1) state_d = S_AR;
            S_AR: if (timer_q == ALLRED_M1) state_d = ped_wait_q ? S_PW : S_BG;
            S_BG: if (exit_b) state_d = S_BY;
            S_BY: if (timer_q == YEL_M1) state_d = S_BR;
            S_BR: if (timer_q == ALLRED_M1) state_d = ped_wait_q ? S_PW : S_AG;
            S_PW: if (timer_q == WALK_M1) state_d = next_b_q ? S_BG : S_AG;
            default: state_d = S_AG;
        endcase
    end

    always_comb begin
        LA   = L_RED;
        LB   = L_RED;
        walk = 1'b0;
        case (state_q)
            S_AG: LA = L_GREEN;
            S_AY: LA = L_YELLOW;
            S_BG: LB = L_GREEN;
            S_BY: LB = L_YELLOW;
            S_PW: walk = 1'b1;
            default: ;
        endcase
    end

    // Dwell timer, pedestrian latch and post-walk green selector.
    always_comb begin
        timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
        ped_wait_d = ped_wait_q;
        next_b_d   = next_b_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end
        if (state_q == S_PW) begin
            if (timer_q == WALK_M1) begin
                ped_wait_d = 1'b0;
            end
        end else if (ped_req) begin
            ped_wait_d = 1'b1;
        end
        if ((state_d == S_AR) && (state_q != S_AR)) begin
            next_b_d = 1'b1;
        end
        if ((state_d == S_BR) && (state_q != S_BR)) begin
            next_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            ped_wait_q <= 1'b0;
            next_b_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            ped_wait_q <= ped_wait_d;
            next_b_q   <= next_b_d;
        end
    end

    assign ped_wait = ped_wait_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a dwell-count reference model.
module tb_traffic_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YEL   = 2;
    localparam int ALLR  = 1;
    localparam int WLK   = 3;

    localparam int P_AG = 0, P_AY = 1, P_AR = 2, P_BG = 3, P_BY = 4, P_BR = 5, P_PW = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       TA = 1'b0;
    logic       TB = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] LA;
    logic [1:0] LB;
    logic       walk;
    logic       ped_wait;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    // Reference model: phase name, cycles spent in it (1 on the first cycle),
    // pending pedestrian flag, and which street was cleared most recently.
    int m_ph;
    int m_dwell;
    bit m_ped;
    bit m_last_a;

    int hist[$];

    traffic_phase_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .TA       (TA),
        .TB       (TB),
        .ped_req  (ped_req),
        .LA       (LA),
        .LB       (LB),
        .walk     (walk),
        .ped_wait (ped_wait),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit ta, input bit tb, input bit pr, input bit rs);
        int nxt;
        bit ped_n;
        if (rs) begin
            m_ph = P_AG; m_dwell = 1; m_ped = 1'b0; m_last_a = 1'b0;
            return;
        end
        nxt   = m_ph;
        ped_n = m_ped || (pr && (m_ph != P_PW));
        case (m_ph)
            P_AG: if (m_dwell >= MIN_G && (tb || m_ped) && (!ta || m_dwell >= MAX_G)) nxt = P_AY;
            P_BG: if (m_dwell >= MIN_G && (ta || m_ped) && (!tb || m_dwell >= MAX_G)) nxt = P_BY;
            P_AY: if (m_dwell == YEL) nxt = P_AR;
            P_BY: if (m_dwell == YEL) nxt = P_BR;
            P_AR: if (m_dwell == ALLR) nxt = m_ped ? P_PW : P_BG;
            P_BR: if (m_dwell == ALLR) nxt = m_ped ? P_PW : P_AG;
            P_PW: if (m_dwell == WLK) begin
                      nxt   = m_last_a ? P_BG : P_AG;
                      ped_n = 1'b0;
                  end
            default: nxt = P_AG;
        endcase
        if (nxt == P_AR) m_last_a = 1'b1;
        if (nxt == P_BR) m_last_a = 1'b0;
        m_dwell = (nxt == m_ph) ? m_dwell + 1 : 1;
        m_ph    = nxt;
        m_ped   = ped_n;
    endtask

    task automatic compare_all();
        logic [1:0] ela, elb;
        ela = (m_ph == P_AG) ? 2'b00 : (m_ph == P_AY) ? 2'b01 : 2'b10;
        elb = (m_ph == P_BG) ? 2'b00 : (m_ph == P_BY) ? 2'b01 : 2'b10;
        chk("phase", 32'(phase), 32'(m_ph));
        chk("LA", 32'(LA), 32'(ela));
        chk("LB", 32'(LB), 32'(elb));
        chk("walk", 32'(walk), 32'(m_ph == P_PW));
        chk("ped_wait", 32'(ped_wait), 32'(m_ped));
    endtask

    task automatic step(input bit ta, input bit tb, input bit pr, input bit rs);
        TA = ta; TB = tb; ped_req = pr; reset = rs;
        @(posedge clk);
        model_step(ta, tb, pr, rs);
        #1;
        compare_all();
        hist.push_back(int'(phase));
    endtask

    task automatic check_runs(input string tag, input int eph[$], input int elen[$]);
        int ph[$];
        int ln[$];
        foreach (hist[i]) begin
            if (ph.size() != 0 && ph[ph.size()-1] == hist[i]) begin
                ln[ln.size()-1] = ln[ln.size()-1] + 1;
            end else begin
                ph.push_back(hist[i]);
                ln.push_back(1);
            end
        end
        chk($sformatf("%s_nruns", tag), 32'(ph.size()), 32'(eph.size()));
        for (int i = 0; i < eph.size() && i < ph.size(); i++) begin
            chk($sformatf("%s_run%0d_phase", tag, i), 32'(ph[i]), 32'(eph[i]));
            chk($sformatf("%s_run%0d_len", tag, i), 32'(ln[i]), 32'(elen[i]));
        end
    endtask

    initial begin
        int eph[$];
        int elen[$];
        int walks;
        bit ta, tb;

        // Reset values
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_LA", 32'(LA), 32'h0);
        chk("rst_LB", 32'(LB), 32'h2);
        chk("rst_walk", 32'(walk), 32'h0);
        chk("rst_ped_wait", 32'(ped_wait), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);

        // Idle long enough to saturate the timer; a wrapped timer would not exit at once
        for (int i = 0; i < 258; i++) step(0, 0, 0, 0);
        chk("idle_phase", 32'(phase), 32'(P_AG));
        step(1, 1, 0, 0);
        chk("sat_exit", 32'(phase), 32'(P_AY));

        // Side demand
        hist.delete();
        step(0, 1, 0, 1);
        for (int i = 0; i < 19; i++) step(0, 1, 0, 0);
        eph = '{P_AG, P_AY, P_AR, P_BG};
        elen = '{4, 2, 1, 13};
        check_runs("side", eph, elen);

        // Contention
        hist.delete();
        step(1, 1, 0, 1);
        for (int i = 0; i < 35; i++) step(1, 1, 0, 0);
        eph = '{P_AG, P_AY, P_AR, P_BG, P_BY, P_BR, P_AG};
        elen = '{10, 2, 1, 10, 2, 1, 10};
        check_runs("contend", eph, elen);

        // Reset during BY
        for (int i = 0; i < 40 && phase != 3'(P_BY); i++) step(1, 1, 0, 0);
        chk("reach_by", 32'(phase), 32'(P_BY));
        step(1, 1, 1, 1);
        chk("midrst_LA", 32'(LA), 32'h0);
        chk("midrst_LB", 32'(LB), 32'h2);
        chk("midrst_walk", 32'(walk), 32'h0);
        chk("midrst_ped_wait", 32'(ped_wait), 32'h0);
        chk("midrst_phase", 32'(phase), 32'h0);

        // Pedestrian during AG with a second request inside PW
        hist.delete();
        walks = 0;
        step(1, 0, 0, 1);
        for (int i = 1; i <= 30; i++) begin
            step(1, 0, (i == 6) || (i == 15), 0);
            if (walk) walks++;
        end
        eph = '{P_AG, P_AY, P_AR, P_PW, P_BG, P_BY, P_BR, P_AG};
        elen = '{10, 2, 1, 3, 4, 2, 1, 8};
        check_runs("ped", eph, elen);
        chk("ped_walk_cycles", 32'(walks), 32'(WLK));

        // PW routing back to A after a B clearance
        hist.delete();
        step(0, 1, 0, 1);
        for (int i = 1; i <= 25; i++) step(i > 7, i <= 7, i == 9, 0);
        eph = '{P_AG, P_AY, P_AR, P_BG, P_BY, P_BR, P_PW, P_AG};
        elen = '{4, 2, 1, 4, 2, 1, 3, 9};
        check_runs("pwroute", eph, elen);

        // Random traffic
        ta = 1'b0;
        tb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) ta = ~ta;
            if ($urandom_range(7, 0) == 0) tb = ~tb;
            step(ta, tb, $urandom_range(15, 0) == 0, $urandom_range(499, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
